hex_label_writer: RTL and testbench

//  Writes a hex value as ASCII characters into the label character RAM through its write port.

---
 rtl/hex_label_writer_pkg.sv | 19 +
 rtl/hex_label_writer_nibble2digit.sv | 11 +
 rtl/hex_label_writer.sv | 138 +++++++++++++
 tb/tb_hex_label_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_label_writer_pkg.sv
// Shared constants, state encoding and ASCII helper for the hex label writer.
package hex_label_writer_pkg;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [7:0] hexAscii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    return ASCII_UPPER_A + ({4'h0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/hex_label_writer_nibble2digit.sv
// Converts one 4-bit nibble into its upper-case ASCII hex numeral.
module nibble2digit
  import hex_label_writer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = hexAscii(nibble);

endmodule

// File: rtl/hex_label_writer.sv
// Writes a buffered hex value as ASCII into the label RAM, one digit per px_clk, at frame_start.
// Optional HEX_LZ_BLANK_EN: leading zero digits (except the last) are written as spaces.
module hex_label_writer
  import hex_label_writer_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int VAL_W     = 8,
  parameter int BASE_ADDR = 30,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              px_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              upd_valid,
  input  logic [VAL_W-1:0]  upd_value,
  output logic              upd_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state;
  logic [VAL_W-1:0]   cur;
  logic [VAL_W-1:0]   nxt;
  logic               pend;
  logic [IDX_W-1:0]   idx;

  logic               accept;
  logic               startWrite;
  logic               lastDigit;
  logic [VAL_W-1:0]   srcVal;
  logic [IDX_W-1:0]   srcIdx;
  logic [3:0]         nibble;
  logic [7:0]         numeral;
  logic               leadZero;
  logic [DATA_W-1:0]  charOut;

  assign upd_ready  = !(state == WRITE && pend);
  assign accept     = upd_valid && upd_ready;
  assign startWrite = (state != WRITE) && frame_start && (pend || accept);
  assign lastDigit  = (int'(idx) == DIGITS - 1);
  assign busy       = (state == WRITE);

  // The character for the next output cycle: digit 0 of the new value at a start
  // (bypassing nxt when an update lands in the same cycle), otherwise digit idx+1 of cur.
  always_comb begin
    int pos;
    srcVal = cur;
    srcIdx = idx + IDX_W'(1);
    if (startWrite) begin
      srcVal = accept ? upd_value : nxt;
      srcIdx = '0;
    end
    pos = DIGITS - 1 - int'(srcIdx);
    if (pos < 0) pos = 0;
    nibble = 4'(srcVal >> (4 * pos));
  end

  nibble2digit uDigit (
    .nibble (nibble),
    .ascii  (numeral)
  );

`ifdef HEX_LZ_BLANK_EN
  logic lzRun;
  assign leadZero = (nibble == 4'h0) && (int'(srcIdx) != DIGITS - 1) && (startWrite || lzRun);
`else
  assign leadZero = 1'b0;
`endif

  assign charOut = leadZero ? DATA_W'(ASCII_SPACE) : DATA_W'(numeral);

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= 1'b0;
      idx      <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      done     <= 1'b0;
`ifdef HEX_LZ_BLANK_EN
      lzRun    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      case (state)
        IDLE, ARMED: begin
          if (startWrite) begin
            pend     <= 1'b0;
            idx      <= '0;
            state    <= WRITE;
            ram_we   <= 1'b1;
            ram_addr <= ADDR_W'(BASE_ADDR + int'(srcIdx));
            ram_din  <= charOut;
`ifdef HEX_LZ_BLANK_EN
            lzRun    <= leadZero;
`endif
          end else if (accept) begin
            pend  <= 1'b1;
            state <= ARMED;
          end
        end
        WRITE: begin
          if (accept) pend <= 1'b1;
          if (lastDigit) begin
            done  <= 1'b1;
            state <= (pend || accept) ? ARMED : IDLE;
          end else begin
            idx      <= idx + IDX_W'(1);
            ram_we   <= 1'b1;
            ram_addr <= ADDR_W'(BASE_ADDR + int'(srcIdx));
            ram_din  <= charOut;
`ifdef HEX_LZ_BLANK_EN
            lzRun    <= leadZero;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Value registers carry data only; their contents are qualified by pend/state.
  always_ff @(posedge px_clk) begin
    if (startWrite) cur <= accept ? upd_value : nxt;
    if (accept)     nxt <= upd_value;
  end

endmodule

// File: tb/tb_hex_label_writer.sv
// Scoreboard bench for hex_label_writer: randomized and directed updates against a transaction-level model.
module tb_hex_label_writer;

  localparam int D    = 2;
  localparam int BASE = 30;

  logic       px_clk = 1'b0;
  bit         clkEn  = 1'b1;
  logic       rst;
  logic       frame_start;
  logic       upd_valid;
  logic [7:0] upd_value;
  logic       upd_ready;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       busy;
  logic       done;

  hex_label_writer #(
    .DIGITS(D), .VAL_W(8), .BASE_ADDR(BASE), .ADDR_W(8), .DATA_W(8)
  ) dut (
    .px_clk      (px_clk),
    .rst         (rst),
    .frame_start (frame_start),
    .upd_valid   (upd_valid),
    .upd_value   (upd_value),
    .upd_ready   (upd_ready),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .busy        (busy),
    .done        (done)
  );

  initial forever begin
    #5;
    if (clkEn) px_clk = ~px_clk;
  end

  int cyc = 0;
  always @(posedge px_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         isDone;
    logic [7:0] addr;
    logic [7:0] din;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: pending value and the cycle range in which the writer is busy.
  bit         mPend = 1'b0;
  logic [7:0] mNxt  = 8'h00;
  int         wrBeg = 1;
  int         wrEnd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] expChar(input logic [7:0] v, input int k);
    int d;
    d = int'((v >> (4 * (D - 1 - k))) & 8'h0F);
`ifdef HEX_LZ_BLANK_EN
    if (k < D - 1 && (v >> (4 * (D - 1 - k))) == 8'h00) return 8'h20;
`endif
    if (d < 10) return 8'(8'h30 + d);
    return 8'(8'h41 + d - 10);
  endfunction

  always @(negedge px_clk) begin
    if (!rst) begin
      if (ram_we || done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output at cycle %0d: we=%0b addr=%0d din=%0h done=%0b, expected nothing",
                   cyc, ram_we, ram_addr, ram_din, done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("out_done", {31'd0, done}, {31'd0, e.isDone});
          check("out_we", {31'd0, ram_we}, {31'd0, !e.isDone});
          if (!e.isDone) begin
            check("ram_addr", {24'd0, ram_addr}, {24'd0, e.addr});
            check("ram_din", {24'd0, ram_din}, {24'd0, e.din});
          end
        end
      end else begin
        check("idle_addr", {24'd0, ram_addr}, 32'd0);
        check("idle_din", {24'd0, ram_din}, 32'd0);
      end
    end
  end

  // One stimulus cycle; called just after a rising edge.
  task automatic drive(input bit fs, input bit v, input logic [7:0] val);
    bit writing, rdy, acc;
    frame_start = fs;
    upd_valid   = v;
    upd_value   = val;
    writing = (cyc >= wrBeg) && (cyc <= wrEnd);
    rdy     = !(writing && mPend);
    check("upd_ready", {31'd0, upd_ready}, {31'd0, rdy});
    check("busy", {31'd0, busy}, {31'd0, writing});
    acc = v && rdy;
    if (!writing && fs && (mPend || acc)) begin
      logic [7:0] w;
      w = acc ? val : mNxt;
      for (int k = 0; k < D; k++)
        sb.push_back('{cyc: cyc + 1 + k, isDone: 1'b0, addr: 8'(BASE + k), din: expChar(w, k)});
      sb.push_back('{cyc: cyc + 1 + D, isDone: 1'b1, addr: 8'h00, din: 8'h00});
      mPend = 1'b0;
      wrBeg = cyc + 1;
      wrEnd = cyc + D;
    end else if (acc) begin
      mNxt  = val;
      mPend = 1'b1;
    end
    @(posedge px_clk);
    #1;
    frame_start = 1'b0;
    upd_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_addr"}, {24'd0, ram_addr}, 32'd0);
    check({tag, "_din"}, {24'd0, ram_din}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, upd_ready}, 32'd1);
  endtask

  // Stop the clock, pulse reset, and resume; the writer must drop outputs without a clock edge.
  task automatic resetMid();
    @(negedge px_clk);
    #1;
    clkEn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    sb.delete();
    mPend = 1'b0;
    wrBeg = 1;
    wrEnd = 0;
    #2;
    rst = 1'b0;
    #1;
    clkEn = 1'b1;
    @(posedge px_clk);
    #1;
  endtask

  initial begin
    logic [7:0] dirVals[3];
    int         guard;
    rst = 1'b1;
    frame_start = 1'b0;
    upd_valid = 1'b0;
    upd_value = 8'h00;
    #1;
    checkResetOutputs("reset");
    @(posedge px_clk);
    @(negedge px_clk);
    rst = 1'b0;
    @(posedge px_clk);
    #1;

    drive(1'b0, 1'b1, 8'h3A);
    drive(1'b1, 1'b0, 8'h00);
    idle(4);

    drive(1'b1, 1'b0, 8'h00);
    idle(10);

    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'h34);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h56);
    drive(1'b0, 1'b1, 8'h78);
    idle(4);
    drive(1'b1, 1'b0, 8'h00);
    idle(4);

    dirVals = '{8'h05, 8'h00, 8'h50};
    foreach (dirVals[i]) begin
      drive(1'b0, 1'b1, dirVals[i]);
      drive(1'b1, 1'b0, 8'h00);
      idle(3);
    end

    drive(1'b1, 1'b1, 8'hFF);
    resetMid();
    idle(3);

    repeat (400) begin
      drive(($urandom % 5) == 0, ($urandom % 3) == 0, 8'($urandom));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    check("drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
